fsm_axi_lite_rd_slv: RTL and testbench

//   AXI4-Lite read-channel responder: accepts one AR request at a time, decodes it against a

---
 rtl/axil_pkg.sv | 15 +
 rtl/axil_rd_addr_dec.sv | 41 ++++
 rtl/fsm_axi_lite_rd_slv.sv | 127 ++++++++++++
 tb/tb_fsm_axi_lite_rd_slv.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite read responder constants and FSM state type
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/axil_rd_addr_dec.sv
// rtl/axil_rd_addr_dec.sv - range/alignment decode and word-index extraction for AR addresses
// Optional misalignment reporting: AXIL_RD_SLV_ALIGN_CHECK_EN
module axil_rd_addr_dec
    import axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic [ADDR_W-1:0]        araddr,
    output logic                     acc_ok,
    output logic [1:0]               err_resp,
    output logic [$clog2(DEPTH)-1:0] word_idx
);

    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] WINDOW = (ADDR_W + 1)'(DEPTH * (DATA_W / 8));

    logic [ADDR_W-1:0] offset;
    logic              in_range;

    // Compare in ADDR_W+1 bits so a window ending at the top of the address map cannot wrap.
    assign offset   = araddr - BASE_ADDR;
    assign in_range = (araddr >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
    assign word_idx = offset[LSB +: IDX_W];

`ifdef AXIL_RD_SLV_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |offset[LSB-1:0];
    assign acc_ok     = in_range && !misaligned;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^offset[LSB-1:0];
    assign acc_ok          = in_range;
`endif

    assign err_resp = in_range ? RESP_SLVERR : RESP_DECERR;

endmodule

// File: rtl/fsm_axi_lite_rd_slv.sv
// rtl/fsm_axi_lite_rd_slv.sv - single-outstanding AXI4-Lite read responder over a fixed-latency memory
// Optional misalignment SLVERR: AXIL_RD_SLV_ALIGN_CHECK_EN
module fsm_axi_lite_rd_slv
    import axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256,
    parameter int                MEM_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic                     mem_rd_en,
    output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data
);

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               rvalid_q, rvalid_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [IDX_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;

    logic               dec_ok;
    logic [1:0]         dec_resp;
    logic [IDX_W-1:0]   dec_idx;

    axil_rd_addr_dec #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_dec (
        .araddr   (araddr),
        .acc_ok   (dec_ok),
        .err_resp (dec_resp),
        .word_idx (dec_idx)
    );

    assign arready     = (state_q == S_IDLE);
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign rvalid      = rvalid_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;

    // cnt_q counts cycles since the read strobe; data is captured when it reaches MEM_LAT.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rvalid_d      = rvalid_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        case (state_q)
            S_IDLE: begin
                if (arvalid) begin
                    if (dec_ok) begin
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = dec_idx;
                        cnt_d         = '0;
                        state_d       = S_MEM;
                    end else begin
                        rdata_d  = '0;
                        rresp_d  = dec_resp;
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            S_MEM, S_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT_C) begin
                    rdata_d  = mem_rd_data;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RESP;
                end else if (MEM_LAT > 1) begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            rvalid_q      <= rvalid_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

endmodule

// File: tb/tb_fsm_axi_lite_rd_slv.sv
// tb/tb_fsm_axi_lite_rd_slv.sv - randomized self-checking bench; instance 0 has MEM_LAT=1, instance 1 MEM_LAT=3
module tb_fsm_axi_lite_rd_slv;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          DEPTH = 256;
    localparam logic [31:0] WIN   = 32'(DEPTH * 4);

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
        int          en_cnt;
        logic [7:0]  en_addr;
        bit          stable;
        bit          ar_low;
        bit          post_ok;
        bit          done;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rready [2];
    logic        mem_rd_en [2];
    logic [7:0]  mem_rd_addr [2];
    logic [31:0] mem_rd_data [2];
    logic [31:0] memv [2][DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] apipe [4];
        logic [3:0] vpipe = '0;

        fsm_axi_lite_rd_slv #(
            .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .MEM_LAT(L)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .araddr      (araddr[g]),
            .arvalid     (arvalid[g]),
            .arready     (arready[g]),
            .rdata       (rdata[g]),
            .rresp       (rresp[g]),
            .rvalid      (rvalid[g]),
            .rready      (rready[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_rd_addr (mem_rd_addr[g]),
            .mem_rd_data (mem_rd_data[g])
        );

        // Memory model: data is only valid exactly L cycles after the strobe, garbage otherwise.
        always @(posedge clk) begin
            vpipe    <= {vpipe[2:0], mem_rd_en[g]};
            apipe[0] <= mem_rd_addr[g];
            apipe[1] <= apipe[0];
            apipe[2] <= apipe[1];
            apipe[3] <= apipe[2];
        end
        assign mem_rd_data[g] = vpipe[L-1] ? memv[g][apipe[L-1]] : 32'hBAD0_BAD0;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic void model(input int d, input logic [31:0] a,
                                  output logic [31:0] data, output logic [1:0] resp, output int lat);
        if (a < BASE || a >= BASE + WIN) begin
            data = 32'h0; resp = 2'b11; lat = 1;
        end
`ifdef AXIL_RD_SLV_ALIGN_CHECK_EN
        else if (a[1:0] != 2'b00) begin
            data = 32'h0; resp = 2'b10; lat = 1;
        end
`endif
        else begin
            data = memv[d][(a - BASE) / 4]; resp = 2'b00; lat = lat_of(d) + 2;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return BASE + WIN + 32'($urandom_range(0, 255) * 4);
        if (k == 1) return 32'($urandom_range(0, 32'h3FFF));
        return BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + ((k == 2) ? 32'($urandom_range(1, 3)) : 32'h0);
    endfunction

    task automatic read_txn(input int d, input logic [31:0] a, input int stall, input bit pend,
                            output txn_t r);
        int n;
        @(negedge clk);
        araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0;
        n = 0;
        while (arready[d] !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1 arvalid[d] = 1'b0;
        r.lat = 0; r.en_cnt = 0; r.en_addr = '0; r.done = 0; r.stable = 1; r.ar_low = 1;
        for (int i = 0; i < 30 && !r.done; i++) begin
            @(negedge clk); r.lat++;
            if (mem_rd_en[d] === 1'b1) begin r.en_cnt++; r.en_addr = mem_rd_addr[d]; end
            if (rvalid[d] === 1'b1) r.done = 1;
        end
        r.data = rdata[d]; r.resp = rresp[d];
        if (pend) begin araddr[d] = a ^ 32'h4; arvalid[d] = 1'b1; end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (rvalid[d] !== 1'b1 || rdata[d] !== r.data || rresp[d] !== r.resp) r.stable = 0;
            if (arready[d] !== 1'b0 || mem_rd_en[d] !== 1'b0) r.ar_low = 0;
        end
        rready[d] = 1'b1;
        @(posedge clk); #1 rready[d] = 1'b0; arvalid[d] = 1'b0;
        @(negedge clk);
        r.post_ok = (rvalid[d] === 1'b0 && arready[d] === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin arvalid[d] = 1'b1; araddr[d] = BASE; end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rvalid[d] !== 1'b0 || mem_rd_en[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_hold d%0d: rvalid=%b mem_rd_en=%b expected 0/0", d, rvalid[d], mem_rd_en[d]);
                end
            end
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (arready[d] !== 1'b1 || rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 ||
                rresp[d] !== 2'b00 || mem_rd_addr[d] !== 8'h0) begin
                n_fail++;
                $display("FAIL reset_values d%0d: arready=%b rvalid=%b rdata=%h rresp=%b addr=%h expected 1/0/0/00/0",
                         d, arready[d], rvalid[d], rdata[d], rresp[d], mem_rd_addr[d]);
            end
            arvalid[d] = 1'b0;
        end
    endtask

    task automatic test_basic();
        txn_t r;
        memv[0][4] = 32'hDEAD_BEEF;
        read_txn(0, BASE + 32'h10, 0, 0, r);
        n_checks++;
        if (!r.done || r.en_cnt != 1 || r.en_addr !== 8'd4) begin
            n_fail++;
            $display("FAIL basic_mem: done=%0d en_cnt=%0d addr=%0d expected 1/1/4", r.done, r.en_cnt, r.en_addr);
        end
        n_checks++;
        if (r.lat != 3 || r.data !== 32'hDEAD_BEEF || r.resp !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_resp: lat=%0d data=%h resp=%b expected 3/deadbeef/00", r.lat, r.data, r.resp);
        end
        n_checks++;
        if (!r.post_ok) begin
            n_fail++;
            $display("FAIL basic_post: rvalid low/arready high after handshake got %0d expected 1", r.post_ok);
        end
    endtask

    task automatic test_out_of_range();
        txn_t r;
        logic [31:0] addrs [3];
        addrs[0] = BASE + WIN; addrs[1] = BASE - 32'h4; addrs[2] = 32'hFFFF_FFFC;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                read_txn(d, addrs[i], 0, 0, r);
                n_checks++;
                if (!r.done || r.en_cnt != 0 || r.lat != 1 || r.resp !== 2'b11 || r.data !== 32'h0) begin
                    n_fail++;
                    $display("FAIL oor d%0d a=%h: en_cnt=%0d lat=%0d resp=%b data=%h expected 0/1/11/0",
                             d, addrs[i], r.en_cnt, r.lat, r.resp, r.data);
                end
            end
        end
    endtask

    task automatic test_stall();
        txn_t r;
        logic [31:0] ed;
        logic [1:0]  er;
        int          el;
        for (int d = 0; d < 2; d++) begin
            read_txn(d, BASE + 32'h3C, 5, 1, r);
            model(d, BASE + 32'h3C, ed, er, el);
            n_checks++;
            if (!r.done || r.data !== ed || r.resp !== er || r.lat != el) begin
                n_fail++;
                $display("FAIL stall_data d%0d: data=%h resp=%b lat=%0d expected %h/%b/%0d", d, r.data, r.resp, r.lat, ed, er, el);
            end
            n_checks++;
            if (!r.stable || !r.ar_low) begin
                n_fail++;
                $display("FAIL stall_hold d%0d: stable=%0d ar_blocked=%0d expected 1/1", d, r.stable, r.ar_low);
            end
            n_checks++;
            if (!r.post_ok) begin
                n_fail++;
                $display("FAIL stall_post d%0d: got %0d expected 1", d, r.post_ok);
            end
        end
    endtask

    task automatic test_misaligned();
        txn_t r;
        logic [31:0] ed;
        logic [1:0]  er;
        int          el;
        read_txn(0, BASE + 32'h2, 0, 0, r);
        model(0, BASE + 32'h2, ed, er, el);
        n_checks++;
        if (!r.done || r.data !== ed || r.resp !== er || r.lat != el || r.en_cnt != ((er == 2'b00) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL misaligned: data=%h resp=%b lat=%0d en=%0d expected %h/%b/%0d", r.data, r.resp, r.lat, r.en_cnt, ed, er, el);
        end
    endtask

    task automatic test_random();
        txn_t r;
        logic [31:0] a, ed;
        logic [1:0]  er;
        int          el, d;
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 1);
            a = rand_addr();
            read_txn(d, a, $urandom_range(0, 2), 0, r);
            model(d, a, ed, er, el);
            n_checks++;
            if (!r.done || r.data !== ed || r.resp !== er || r.lat != el ||
                r.en_cnt != ((er == 2'b00) ? 1 : 0) ||
                (er == 2'b00 && r.en_addr !== 8'((a - BASE) / 4))) begin
                n_fail++;
                $display("FAIL random d%0d a=%h: data=%h resp=%b lat=%0d en=%0d expected %h/%b/%0d",
                         d, a, r.data, r.resp, r.lat, r.en_cnt, ed, er, el);
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t r;
        logic [31:0] ed;
        logic [1:0]  er;
        int          el, n;
        bit          seen;
        @(negedge clk);
        araddr[1] = BASE + 32'h20; arvalid[1] = 1'b1;
        n = 0;
        while (arready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 arvalid[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_rd_en[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_strobe: mem_rd_en=%b expected 1", mem_rd_en[1]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_rd_en[1] !== 1'b0 || arready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_async: mem_rd_en=%b arready=%b expected 0/1", mem_rd_en[1], arready[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid[1] !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_no_beat: rvalid seen=%0d expected 0", seen);
        end
        read_txn(1, BASE + 32'h24, 0, 0, r);
        model(1, BASE + 32'h24, ed, er, el);
        n_checks++;
        if (!r.done || r.data !== ed || r.resp !== er || r.lat != el) begin
            n_fail++;
            $display("FAIL mid_next: data=%h resp=%b lat=%0d expected %h/%b/%0d", r.data, r.resp, r.lat, ed, er, el);
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] qd [$];
        logic [1:0]  qr [$];
        logic [31:0] ed, xd;
        logic [1:0]  er, xr;
        int          el, cyc, last_hs, exp_gap, n_hs, n_beats;
        bit          hs;
        cyc = 0; last_hs = -1; exp_gap = 0; n_hs = 0; n_beats = 0;
        @(negedge clk);
        rready[d] = 1'b1; araddr[d] = rand_addr(); arvalid[d] = 1'b1;
        while (n_beats < 12 && cyc < 500) begin
            hs = 0;
            if (rvalid[d] === 1'b1) begin
                n_checks++;
                if (qd.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra d%0d: beat with no request outstanding", d);
                end else begin
                    xd = qd.pop_front(); xr = qr.pop_front();
                    if (rdata[d] !== xd || rresp[d] !== xr) begin
                        n_fail++;
                        $display("FAIL b2b_beat d%0d: data=%h resp=%b expected %h/%b", d, rdata[d], rresp[d], xd, xr);
                    end
                end
                n_beats++;
            end
            if (arready[d] === 1'b1 && arvalid[d] === 1'b1) begin
                if (last_hs >= 0) begin
                    n_checks++;
                    if (cyc - last_hs != exp_gap) begin
                        n_fail++;
                        $display("FAIL b2b_gap d%0d: gap=%0d expected %0d", d, cyc - last_hs, exp_gap);
                    end
                end
                model(d, araddr[d], ed, er, el);
                qd.push_back(ed); qr.push_back(er);
                last_hs = cyc; exp_gap = el + 1; n_hs++; hs = 1;
            end
            @(posedge clk); #1;
            if (hs) begin
                araddr[d] = rand_addr();
                if (n_hs >= 12) arvalid[d] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (n_beats != 12) begin
            n_fail++;
            $display("FAIL b2b_count d%0d: beats=%0d expected 12", d, n_beats);
        end
        rready[d] = 1'b0; arvalid[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) memv[d][i] = $urandom;
        end
        test_reset();
        test_basic();
        test_out_of_range();
        test_stall();
        test_misaligned();
        test_random();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
